// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the NZVC flag bundle.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    // Opcode encodings, also used by the instruction decoder.
    typedef enum logic [ALU_OP_W-1:0] {
        OP_PASSB = 3'b000,
        OP_SHL   = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110,
        OP_SHR   = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: eight ops plus NZVC flag generation.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;

    // Select the op result and derive flags; shifts use one extra bit to catch the last bit shifted out.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
        b_op    = (op == OP_SUB) ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, (op == OP_SUB)};
        shamt   = b[SHW-1:0];
        shl_ext = {1'b0, a} << shamt;
        shr_ext = {a, 1'b0} >> shamt;
        result  = b;
        flags   = '0;

        case (op)
            OP_PASSB: result = b;
            OP_SHL: begin
                result  = shl_ext[WIDTH-1:0];
                flags.c = shl_ext[WIDTH];
            end
            OP_ADD, OP_SUB: begin
                result  = sum[WIDTH-1:0];
                flags.c = sum[WIDTH];
                flags.v = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHR: begin
                result  = shr_ext[WIDTH:1];
                flags.c = shr_ext[0];
            end
            default: result = b;
        endcase

        flags.n = result[WIDTH-1];
        flags.z = (result == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes and an architectural NZVC register.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       cntrl,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    alu_op_e          s1_op;
    logic             s1_sf;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    alu_flags_t       s2_flags;
    logic             s2_sf;

    alu_flags_t       flag_reg;

    logic [WIDTH-1:0] core_result;
    alu_flags_t       core_flags;

    logic s2_adv;
    logic s1_adv;
    logic in_fire;
    logic retire;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_op),
        .result (core_result),
        .flags  (core_flags)
    );

    // Advance conditions; in_ready depends only on pipeline state and out_ready.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign retire   = s2_valid && out_ready;

    // Stage 1: capture operands on an input handshake.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
        end
        // NOTE: operand registers are qualified by s1_valid, so they need no reset.
        if (in_fire) begin
            s1_a  <= a;
            s1_b  <= b;
            s1_op <= alu_op_e'(cntrl);
            s1_sf <= set_flags;
        end
    end

    // Stage 2: register the core output when S1 holds an op and S2 is empty or retiring.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
            s2_sf     <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= core_result;
                s2_flags  <= core_flags;
                s2_sf     <= s1_sf;
            end
        end
    end

    // Architectural flag register: commit S2 flags when a set_flags op retires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_reg <= '0;
        end else if (retire && s2_sf) begin
            flag_reg <= s2_flags;
        end
    end

    assign out_valid = s2_valid;
    assign result    = s2_result;
    assign negative  = s2_flags.n;
    assign zero      = s2_flags.z;
    assign overflow  = s2_flags.v;
    assign carry_out = s2_flags.c;
    assign flag_n    = flag_reg.n;
    assign flag_z    = flag_reg.z;
    assign flag_v    = flag_reg.v;
    assign flag_c    = flag_reg.c;

endmodule
